// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM sequencing fetch (T0-T2) and ALU execute (T3-T5) steps for a simple datapath.
module control_sequencer (
    input  logic        clock,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] ir,
    output logic [31:0] enc_input,
    output logic [31:0] reg_enable,
    output logic [5:0]  ALU_Sel,
    output logic        read,
    output logic        write,
    output logic        incPC,
    output logic [3:0]  Gra,
    output logic [3:0]  Grb,
    output logic [3:0]  Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [3:0]  state,
    output logic        halted
);
    typedef enum logic [3:0] {
        IDLE = 4'b1111,
        T0   = 4'b0000,
        T1   = 4'b0001,
        T2   = 4'b0010,
        T3   = 4'b0011,
        T4   = 4'b0100,
        T5   = 4'b0101,
        HALT = 4'b1000
    } state_t;

    state_t     st, nst;
    logic [4:0] op;
    logic       is_r, is_i;
    logic [5:0] sel;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign is_r      = op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    assign is_i      = op inside {5'b01100, 5'b01101, 5'b01110};
    assign unused_ir = ^ir[14:0];

    always_comb begin
        sel = (op == 5'b00011 || op == 5'b01100) ? 6'd3 :
              (op == 5'b00100)                   ? 6'd4 :
              (op == 5'b00101 || op == 5'b01101) ? 6'd5 :
              (op == 5'b00110 || op == 5'b01110) ? 6'd6 : 6'd0;
    end

    always_ff @(posedge clock or posedge clr) begin
        if (clr)
            st <= IDLE;
        else
            st <= nst;
    end

    always_comb begin
        nst = IDLE;
        case (st)
            IDLE: nst = run ? T0 : IDLE;
            T0:   nst = T1;
            T1:   nst = T2;
            T2:   nst = (is_r || is_i) ? T3 : (op == 5'b11011) ? HALT : run ? T0 : IDLE;
            T3:   nst = T4;
            T4:   nst = T5;
            T5:   nst = run ? T0 : IDLE;
            HALT: nst = HALT;
            default: nst = IDLE;
        endcase
    end

    // Every output is a decode of st and ir only; run never reaches here.
    always_comb begin
        enc_input  = '0;
        reg_enable = '0;
        ALU_Sel    = '0;
        read       = 1'b0;
        incPC      = 1'b0;
        Gra        = '0;
        Grb        = '0;
        Grc        = '0;
        Rin        = 1'b0;
        Rout       = 1'b0;
        case (st)
            T0: begin
                enc_input[20]  = 1'b1;
                reg_enable[23] = 1'b1;
                incPC          = 1'b1;
            end
            T1: begin
                read           = 1'b1;
                reg_enable[22] = 1'b1;
            end
            T2: begin
                enc_input[22]  = 1'b1;
                reg_enable[21] = 1'b1;
            end
            T3: begin
                Grb            = ir[22:19];
                Rout           = 1'b1;
                reg_enable[24] = 1'b1;
            end
            T4: begin
                Grc            = is_r ? ir[18:15] : 4'd0;
                Rout           = is_r;
                enc_input[25]  = is_i;
                ALU_Sel        = sel;
                reg_enable[19] = 1'b1;
            end
            T5: begin
                enc_input[19]  = 1'b1;
                Gra            = ir[26:23];
                Rin            = 1'b1;
            end
            default: ;
        endcase
    end

    assign write  = 1'b0;
    assign BAout  = 1'b0;
    assign state  = st;
    assign halted = (st == HALT);
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
- REQ-001: The block SHALL have one clock and an asynchronous, active-high reset. Ports are named as in the datapath: clock and clr.
- REQ-002: clock  input  1  rising-edge system clock shared with datapath.
- REQ-003: clr  input  1  asynchronous active-high reset.
- REQ-004: run  input  1  level; permits leaving IDLE to start fetching.
- REQ-005: ir  input  32  current IR contents from datapath; opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
- REQ-006: enc_input  output  32  one-hot bus-source select; bit map PC=20, MAR=23, Zlow=19, MDR=22, IR=21, Y=24, C=25.
- REQ-007: reg_enable  output  32  register load enables; same bit map as enc_input.
- REQ-008: ALU_Sel  output  6  ALU operation code.
- REQ-009: read, write, incPC  output  1 each  memory read, memory write (always 0 in this block), PC increment.
- REQ-010: Gra, Grb, Grc  output  4 each  register-file select fields.
- REQ-011: Rin, Rout, BAout  output  1 each  register-file load, drive, base-address drive (BAout always 0).
- REQ-012: state  output  4  present state code, for debug.
- REQ-013: halted  output  1  high while in HALT.

Function
- REQ-014: State codes SHALL be IDLE=4'b1111, T0=0000, T1=0001, T2=0010, T3=0011, T4=0100, T5=0101, HALT=4'b1000. The state register SHALL advance exactly once per rising clock edge.
- REQ-015: All outputs SHALL be Moore: a pure decode of the state register plus ir. No output may depend on run.
- REQ-016: IDLE: all controls 0. Go to T0 when run=1, else stay in IDLE.
- REQ-017: T0: enc_input[20]=1, reg_enable[23]=1, incPC=1. Next state is T1.
- REQ-018: T1: read=1, reg_enable[22]=1. Next state is T2.
- REQ-019: T2: enc_input[22]=1, reg_enable[21]=1. Next state SHALL be decided from ir latched at this edge:
  - ALU opcodes: go to T3.
  - halt (11011): go to HALT.
  - nop (11010) and any other opcode: go to T0 if run=1, else IDLE.
- REQ-020: ALU opcodes and their ALU_Sel values:
  - R-type: add 00011→3, sub 00100→4, and 00101→5, or 00110→6.
  - I-type: addi 01100→3, andi 01101→5, ori 01110→6.
- REQ-021: T3: Grb=ir[22:19], Rout=1, reg_enable[24]=1. Next state is T4.
- REQ-022: T4, R-type: Grc=ir[18:15], Rout=1, ALU_Sel per REQ-020, reg_enable[19]=1.
- REQ-023: T4, I-type: enc_input[25]=1, ALU_Sel per REQ-020, reg_enable[19]=1. Next state is T5 for both R-type and I-type.
- REQ-024: T5: enc_input[19]=1, Gra=ir[26:23], Rin=1. Next state is T0 if run=1, else IDLE.
- REQ-025: At most one enc_input bit SHALL be high in any state. Outside the states that name a field, Gra, Grb, Grc and ALU_Sel SHALL be 0.
- REQ-026: HALT: all controls 0, halted=1. Stay in HALT regardless of run until clr.
- REQ-027: If run drops mid-instruction, the current instruction SHALL complete through its last state before returning to IDLE.
- REQ-028: Latency: an ALU instruction takes 6 cycles (T0–T5); nop takes 3 cycles; back-to-back instructions have no bubble.

Reset
- REQ-029: clr=1 SHALL force state=IDLE immediately, without waiting for a clock edge, and drive every output to 0 (halted=0), including during T0–T5 or HALT.
- REQ-030: After clr falls, the block SHALL leave IDLE only on a rising edge with run=1.

Verification
- REQ-031: Reset, then run=1 with an addi word (opcode 01100, ra=2, rb=1) presented from T2. Expected state sequence and outputs:
  - state 0,1,2,3,4,5,0.
  - T3: Grb=1.
  - T4: enc_input[25]=1, ALU_Sel=3.
  - T5: Gra=2, Rin=1, enc_input[19]=1.
- REQ-032: add with ra=5, rb=6, rc=7 → T4 shows Grc=7, Rout=1, ALU_Sel=3, reg_enable[19]=1; T5 shows Gra=5.
- REQ-033: Opcode 11011 at T2 → next state HALT, halted=1. Holding run=1 for 10 cycles leaves all controls at 0. Pulsing clr returns the block to IDLE.
- REQ-034: nop with run=1 → state 0,1,2,0; incPC high exactly once per 3 cycles.
- REQ-035: Assert clr asynchronously (between edges) during T4 → outputs and state go to 0/IDLE before the next edge. Drop run during T3 → the instruction finishes T5, then the block goes to IDLE.
- REQ-036: Every cycle, assert the enc_input one-hot/zero property, write=0 and BAout=0.
